mult_rr_sequencer: RTL and testbench

- Shares one sequential shift-add unsigned multiplier (start/ready interface, NB-bit operands, 2*NB-bit product) among NREQ requesters.
- Round-robin arbitration between requesters.
- Issues the start pulse, waits for the multiplier's ready, and returns the product tagged with the requester id.
- Sits between client blocks and the single multiplier instance; the multiplier is instantiated outside this block and wired to the mul_* ports.

---
 rtl/mult_rr_sequencer.sv | 143 ++++++++++++++
 tb/tb_mult_rr_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_sequencer.sv
// Round-robin front end that shares one external start/ready shift-add multiplier among NREQ
// requesters. Optional macro MULT_ZERO_BYPASS_EN answers zero-operand requests without the multiplier.
module mult_rr_sequencer #(
  parameter int unsigned NB   = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NB-1:0]   req_a,
  input  logic [NREQ*NB-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [2*NB-1:0]      resp_product,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic                 mul_start,
  output logic [NB-1:0]        mul_a,
  output logic [NB-1:0]        mul_b,
  input  logic [2*NB-1:0]      mul_product,
  input  logic                 mul_ready
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NB-1:0]   a_q, a_d, b_q, b_d;
  logic [2*NB-1:0] prod_q, prod_d;

  logic [2*NREQ-1:0] req_rot;
  logic [IDW-1:0]    off;
  logic [IDW:0]      sum;
  logic [IDW-1:0]    gnt_id;
  logic [IDW-1:0]    ptr_next;
  logic              any_req;
  logic [NB-1:0]     sel_a, sel_b;

  // Rotate so the pointer sits at bit 0; the lowest set bit is then the round-robin winner.
  always_comb begin
    req_rot = {req, req} >> ptr_q;
    any_req = 1'b0;
    off     = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any_req = 1'b1;
        off     = IDW'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (IDW+1)'(NREQ)) begin
      sum = sum - (IDW+1)'(NREQ);
    end
    gnt_id = sum[IDW-1:0];
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (gnt_id == IDW'(k)) begin
        sel_a = req_a[k*NB +: NB];
        sel_b = req_b[k*NB +: NB];
      end
    end
  end

  assign ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          a_d   = sel_a;
          b_d   = sel_b;
          id_d  = gnt_id;
          ptr_d = ptr_next;
`ifdef MULT_ZERO_BYPASS_EN
          if (sel_a == '0 || sel_b == '0) begin
            prod_d  = '0;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
`else
          state_d = StIssue;
`endif
        end
      end
      StIssue: state_d = StWait;
      // Ready is only trusted here: the multiplier has no reset and its flag is stale in ISSUE.
      StWait: begin
        if (mul_ready) begin
          prod_d  = mul_product;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  assign gnt          = (state_q == StIdle && any_req) ? (NREQ'(1) << gnt_id) : '0;
  assign resp_valid   = (state_q == StResp);
  assign resp_id      = id_q;
  assign resp_product = prod_q;
  assign busy         = (state_q != StIdle);
  assign mul_start    = (state_q == StIssue);
  assign mul_a        = a_q;
  assign mul_b        = b_q;

endmodule

// File: tb/tb_mult_rr_sequencer.sv
// Directed bench for mult_rr_sequencer with a behavioural start/ready multiplier and a
// grant-to-response scoreboard. Honours MULT_ZERO_BYPASS_EN when computing zero-operand latency.
module tb_mult_rr_sequencer;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_a, req_b;
  logic [3:0]  gnt;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] resp_product;
  logic        resp_ready;
  logic        busy, mul_start;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_product;
  logic        mul_ready;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct packed {logic [1:0] id; logic [15:0] prod;} exp_t;
  exp_t sb[$];
  int   gorder[$];
  int   gcyc[$];
  int   gcount = 0;

  mult_rr_sequencer #(.NB(8), .NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_product(resp_product),
    .resp_ready(resp_ready), .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_ready(mul_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: ready rises NB+1 cycles after the start edge, no reset.
  logic [4:0]  mcnt = '0;
  logic        mrun = 1'b0;
  logic [15:0] mprod = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      mprod <= mul_a * mul_b;
      mcnt  <= 5'(NB);
      mrun  <= 1'b1;
    end else if (mrun && mcnt != 0) begin
      mcnt <= mcnt - 5'd1;
    end
  end
  assign mul_ready   = mrun && (mcnt == 0);
  assign mul_product = mprod;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: push on grant, pop on handshake.
  always begin
    int          gid;
    exp_t        e;
    logic [15:0] p;
    @(negedge clk);
    #3;
    if (rst_n === 1'b1) begin
      if (gnt != 4'b0) begin
        gid = 0;
        for (int i = 0; i < 4; i++) if (gnt[i]) gid = i;
        check("gnt_onehot", $onehot(gnt), 1);
        p = req_a[gid*8 +: 8] * req_b[gid*8 +: 8];
        sb.push_back({gid[1:0], p});
        gorder.push_back(gid);
        gcyc.push_back(cyc);
        gcount++;
      end
      if (resp_valid && resp_ready) begin
        check("sb_nonempty_at_resp", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_resp_id", resp_id, e.id);
          check("sb_resp_product", resp_product, e.prod);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_resp_id"}, resp_id, 0);
    check({tag, "_resp_product"}, resp_product, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
  endtask

  // One isolated request with resp_ready high; cycle k counts from the grant cycle.
  task automatic single(input int id, input logic [7:0] a, input logic [7:0] b);
    logic        byp;
    int          lat;
    logic [15:0] p;
    p   = a * b;
    byp = 1'b0;
`ifdef MULT_ZERO_BYPASS_EN
    byp = (a == 0) || (b == 0);
`endif
    lat = byp ? 1 : NB + 3;
    @(negedge clk);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req[id] = 1'b1;
    #1;
    check("single_gnt", gnt, 32'd1 << id);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) req[id] = 1'b0;
      #1;
      check("single_mul_start", mul_start, !byp && k == 1);
      check("single_resp_valid", resp_valid, k == lat);
      check("single_busy", busy, k <= lat);
      if (k == lat) begin
        check("single_resp_id", resp_id, id);
        check("single_resp_product", resp_product, p);
      end
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (c < 60 && (busy !== 1'b0 || sb.size() != 0)) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("drain", busy == 1'b0 && sb.size() == 0, 1);
  endtask

  initial begin
    int exp_ord[7];
    int c;
    logic seen;
    exp_ord = '{0, 1, 2, 3, 0, 2, 0};
    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    single(1, 8'd13, 8'd11);
    single(0, 8'd255, 8'd255);
    single(0, 8'd1, 8'd200);

    // Sustained requests from all four, then 0101 with the pointer at 1.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    gcount = 0; gorder.delete(); gcyc.delete();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(10 + 3 * i);
      req_b[i*8 +: 8] = 8'(20 + 7 * i);
    end
    req = 4'b1111;
    c = 0;
    while (c < 100 && gcount < 5) begin @(negedge clk); c++; end
    req = 4'b0101;
    c = 0;
    while (c < 100 && gcount < 7) begin @(negedge clk); c++; end
    req = 4'b0000;
    check("rr_grant_count", gcount, 7);
    for (int i = 0; i < 7; i++)
      check("rr_order", gorder.size() > i ? gorder[i] : 99, exp_ord[i]);
    for (int i = 0; i < 6; i++)
      check("rr_spacing", gcyc.size() > i + 1 ? gcyc[i+1] - gcyc[i] : 0, NB + 4);
    drain();

    // Backpressure: hold the response 5 cycles while requester 3 waits.
    @(negedge clk);
    resp_ready = 1'b0;
    req_a[15:8] = 8'd21; req_b[15:8] = 8'd34;
    req_a[31:24] = 8'd99; req_b[31:24] = 8'd3;
    req = 4'b1010;
    #1;
    check("bp_gnt", gnt, 4'b0010);
    @(negedge clk);
    req[1] = 1'b0;
    c = 0;
    while (c < 30 && resp_valid !== 1'b1) begin @(negedge clk); #1; c++; end
    check("bp_valid_seen", resp_valid, 1);
    repeat (5) begin
      check("bp_hold_valid", resp_valid, 1);
      check("bp_hold_id", resp_id, 1);
      check("bp_hold_product", resp_product, 714);
      check("bp_no_gnt", gnt, 0);
      @(negedge clk);
      #1;
    end
    resp_ready = 1'b1;
    check("bp_handshake_valid", resp_valid, 1);
    check("bp_handshake_no_gnt", gnt, 0);
    @(negedge clk);
    #1;
    check("bp_next_gnt", gnt, 4'b1000);
    check("bp_valid_dropped", resp_valid, 0);
    @(negedge clk);
    req[3] = 1'b0;
    drain();

    // Reset while waiting on the multiplier.
    @(negedge clk);
    req_a[23:16] = 8'd5; req_b[23:16] = 8'd6;
    req[2] = 1'b1;
    #1;
    check("abort_gnt", gnt, 4'b0100);
    @(negedge clk);
    req[2] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    check("abort_mul_a_before", mul_a, 5);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (14) begin @(negedge clk); #1; if (resp_valid) seen = 1'b1; end
    check("abort_no_resp", seen, 0);
    single(0, 8'd7, 8'd9);

    single(2, 8'd0, 8'd200);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
